// File: rtl/zap_regf_pkg.sv
// Shared definitions for the register-file write scheduler.
//   REGF_AW / REGF_DW   : register address / data width
//   REGF_ENTRIES        : number of architectural registers
//   REGF_DEPTH          : default pending-write FIFO depth
//   issue_e             : how the RAM write ports are used in a cycle
package zap_regf_pkg;

    localparam int unsigned REGF_AW      = 6;
    localparam int unsigned REGF_DW      = 32;
    localparam int unsigned REGF_ENTRIES = 64;
    localparam int unsigned REGF_DEPTH   = 4;

    typedef enum logic [1:0] {
        ISS_NONE,   // nothing to write
        ISS_ONE,    // single candidate, mirrored on both ports
        ISS_TWO,    // two candidates, distinct addresses
        ISS_MERGE   // two candidates, same address: younger on both ports
    } issue_e;

endpackage

// File: rtl/zap_regf_fwd_mux.sv
// Read-forwarding mux for one read port.
//   i_rd_addr      : decode read address
//   i_ent_valid    : FIFO entry valid, index 0 = oldest
//   i_ent_addr/data: FIFO entries in age order (index 0 = oldest)
//   i_ram_rd_data  : RAM read data for i_rd_addr
//   o_rd_data      : youngest matching FIFO data, else RAM data
module zap_regf_fwd_mux #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 32
) (
    input  logic [AW-1:0]             i_rd_addr,
    input  logic [DEPTH-1:0]          i_ent_valid,
    input  logic [DEPTH-1:0][AW-1:0]  i_ent_addr,
    input  logic [DEPTH-1:0][DW-1:0]  i_ent_data,
    input  logic [DW-1:0]             i_ram_rd_data,
    output logic [DW-1:0]             o_rd_data
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entries are scanned oldest to youngest, so the last hit wins.
    always_comb begin
        o_rd_data = i_ram_rd_data;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_ent_valid[IW'(i)] && (i_ent_addr[IW'(i)] == i_rd_addr))
                o_rd_data = i_ent_data[IW'(i)];
        end
    end

endmodule

// File: rtl/zap_regf_wr_sched.sv
// Write-port scheduler and read-forwarding front end for the register RAM.
//   i_wr_valid/addr/data_a,b,c : three write requests, a oldest, c youngest
//   o_wr_ready                 : shared ready, count < DEPTH (registered state)
//   o_ram_wen, o_ram_wr_*      : two RAM write ports
//   i_rd_addr_a..d             : decode read addresses
//   i_ram_rd_data_a..d         : RAM read data
//   o_rd_data_a..d             : read data with pending writes forwarded
//   o_pending                  : FIFO occupancy
module zap_regf_wr_sched
    import zap_regf_pkg::*;
#(
    parameter int unsigned DEPTH = REGF_DEPTH,
    parameter int unsigned AW    = REGF_AW,
    parameter int unsigned DW    = REGF_DW
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_wr_valid_a,
    input  logic [AW-1:0]               i_wr_addr_a,
    input  logic [DW-1:0]               i_wr_data_a,
    input  logic                        i_wr_valid_b,
    input  logic [AW-1:0]               i_wr_addr_b,
    input  logic [DW-1:0]               i_wr_data_b,
    input  logic                        i_wr_valid_c,
    input  logic [AW-1:0]               i_wr_addr_c,
    input  logic [DW-1:0]               i_wr_data_c,
    output logic                        o_wr_ready,
    output logic                        o_ram_wen,
    output logic [AW-1:0]               o_ram_wr_addr_a,
    output logic [AW-1:0]               o_ram_wr_addr_b,
    output logic [DW-1:0]               o_ram_wr_data_a,
    output logic [DW-1:0]               o_ram_wr_data_b,
    input  logic [AW-1:0]               i_rd_addr_a,
    input  logic [AW-1:0]               i_rd_addr_b,
    input  logic [AW-1:0]               i_rd_addr_c,
    input  logic [AW-1:0]               i_rd_addr_d,
    input  logic [DW-1:0]               i_ram_rd_data_a,
    input  logic [DW-1:0]               i_ram_rd_data_b,
    input  logic [DW-1:0]               i_ram_rd_data_c,
    input  logic [DW-1:0]               i_ram_rd_data_d,
    output logic [DW-1:0]               o_rd_data_a,
    output logic [DW-1:0]               o_rd_data_b,
    output logic [DW-1:0]               o_rd_data_c,
    output logic [DW-1:0]               o_rd_data_d,
    output logic [$clog2(DEPTH+1)-1:0]  o_pending
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [PW:0]   PTR_DEPTH = (PW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [DEPTH-1:0][AW-1:0] fifo_addr_q, fifo_addr_d;
    logic [DEPTH-1:0][DW-1:0] fifo_data_q, fifo_data_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;

    logic                     ready, acc_a, acc_b, acc_c;
    logic [1:0]               n_inc, pops, used_inc, push_n;
    logic [AW-1:0]            inc_addr0, inc_addr1, c0_addr, c1_addr, pv_addr0, pv_addr1;
    logic [DW-1:0]            inc_data0, inc_data1, c0_data, c1_data, pv_data0, pv_data1;
    logic                     has_c0, has_c1;
    issue_e                   issue;
    logic [DEPTH-1:0]         ord_valid;
    logic [DEPTH-1:0][AW-1:0] ord_addr;
    logic [DEPTH-1:0][DW-1:0] ord_data;

    // p + off modulo DEPTH; both operands are below DEPTH so one fold suffices.
    function automatic logic [PW-1:0] ring_add(input logic [PW-1:0] p, input logic [PW-1:0] off);
        logic [PW:0] s;
        s = {1'b0, p} + {1'b0, off};
        if (s >= PTR_DEPTH) s = s - PTR_DEPTH;
        return s[PW-1:0];
    endfunction

    always_comb begin
        ready = (count_q < CNT_DEPTH);
        acc_a = i_wr_valid_a & ready;
        acc_b = i_wr_valid_b & ready;
        acc_c = i_wr_valid_c & ready;
        n_inc = {1'b0, acc_a} + {1'b0, acc_b} + {1'b0, acc_c};

        // FIFO viewed in age order; index 0 is the oldest entry.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ord_addr[PW'(i)]  = fifo_addr_q[ring_add(rd_ptr_q, PW'(i))];
            ord_data[PW'(i)]  = fifo_data_q[ring_add(rd_ptr_q, PW'(i))];
            ord_valid[PW'(i)] = (CW'(i) < count_q);
        end

        // Accepted incoming requests compacted in age order; third is always c.
        inc_addr0 = acc_a ? i_wr_addr_a : (acc_b ? i_wr_addr_b : i_wr_addr_c);
        inc_data0 = acc_a ? i_wr_data_a : (acc_b ? i_wr_data_b : i_wr_data_c);
        inc_addr1 = (acc_a & acc_b) ? i_wr_addr_b : i_wr_addr_c;
        inc_data1 = (acc_a & acc_b) ? i_wr_data_b : i_wr_data_c;

        // First two candidates: FIFO oldest first, then incoming.
        pops     = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        used_inc = (n_inc < (2'd2 - pops)) ? n_inc : (2'd2 - pops);
        push_n   = n_inc - used_inc;
        has_c0   = (count_q != '0) | (n_inc != 2'd0);
        has_c1   = (pops == 2'd2) | ((pops == 2'd1) & (n_inc != 2'd0)) | (n_inc >= 2'd2);
        c0_addr  = (pops != 2'd0) ? ord_addr[0] : inc_addr0;
        c0_data  = (pops != 2'd0) ? ord_data[0] : inc_data0;
        c1_addr  = (pops == 2'd2) ? ord_addr[1] : ((pops == 2'd1) ? inc_addr0 : inc_addr1);
        c1_data  = (pops == 2'd2) ? ord_data[1] : ((pops == 2'd1) ? inc_data0 : inc_data1);

        if (!has_c0)                 issue = ISS_NONE;
        else if (!has_c1)            issue = ISS_ONE;
        else if (c0_addr == c1_addr) issue = ISS_MERGE;
        else                         issue = ISS_TWO;

        o_ram_wen       = (issue != ISS_NONE) & ~i_reset;
        o_ram_wr_addr_a = c0_addr;
        o_ram_wr_data_a = c0_data;
        o_ram_wr_addr_b = c0_addr;
        o_ram_wr_data_b = c0_data;
        case (issue)
            ISS_TWO: begin
                o_ram_wr_addr_b = c1_addr;
                o_ram_wr_data_b = c1_data;
            end
            ISS_MERGE: begin
                o_ram_wr_addr_a = c1_addr;
                o_ram_wr_data_a = c1_data;
                o_ram_wr_addr_b = c1_addr;
                o_ram_wr_data_b = c1_data;
            end
            default: ;
        endcase

        // Leftover incoming requests are inc[used_inc .. n_inc-1].
        pv_addr0 = (used_inc == 2'd0) ? inc_addr0 : ((used_inc == 2'd1) ? inc_addr1 : i_wr_addr_c);
        pv_data0 = (used_inc == 2'd0) ? inc_data0 : ((used_inc == 2'd1) ? inc_data1 : i_wr_data_c);
        pv_addr1 = (used_inc == 2'd0) ? inc_addr1 : i_wr_addr_c;
        pv_data1 = (used_inc == 2'd0) ? inc_data1 : i_wr_data_c;

        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        if (push_n >= 2'd1) begin
            fifo_addr_d[wr_ptr_q] = pv_addr0;
            fifo_data_d[wr_ptr_q] = pv_data0;
        end
        if (push_n >= 2'd2) begin
            fifo_addr_d[ring_add(wr_ptr_q, PW'(1))] = pv_addr1;
            fifo_data_d[ring_add(wr_ptr_q, PW'(1))] = pv_data1;
        end
        if (push_n == 2'd3) begin
            fifo_addr_d[ring_add(wr_ptr_q, PW'(2))] = i_wr_addr_c;
            fifo_data_d[ring_add(wr_ptr_q, PW'(2))] = i_wr_data_c;
        end

        rd_ptr_d = ring_add(rd_ptr_q, PW'(pops));
        wr_ptr_d = ring_add(wr_ptr_q, PW'(push_n));
        count_d  = count_q - CW'(pops) + CW'(push_n);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fifo_addr_q <= '0;
            fifo_data_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign o_wr_ready = ready;
    assign o_pending  = count_q;

    a_count_bound: assert property (@(posedge i_clk) disable iff (i_reset) count_q <= CNT_DEPTH);

    zap_regf_fwd_mux #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_a (
        .i_rd_addr(i_rd_addr_a), .i_ent_valid(ord_valid), .i_ent_addr(ord_addr),
        .i_ent_data(ord_data), .i_ram_rd_data(i_ram_rd_data_a), .o_rd_data(o_rd_data_a));
    zap_regf_fwd_mux #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_b (
        .i_rd_addr(i_rd_addr_b), .i_ent_valid(ord_valid), .i_ent_addr(ord_addr),
        .i_ent_data(ord_data), .i_ram_rd_data(i_ram_rd_data_b), .o_rd_data(o_rd_data_b));
    zap_regf_fwd_mux #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_c (
        .i_rd_addr(i_rd_addr_c), .i_ent_valid(ord_valid), .i_ent_addr(ord_addr),
        .i_ent_data(ord_data), .i_ram_rd_data(i_ram_rd_data_c), .o_rd_data(o_rd_data_c));
    zap_regf_fwd_mux #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_d (
        .i_rd_addr(i_rd_addr_d), .i_ent_valid(ord_valid), .i_ent_addr(ord_addr),
        .i_ent_data(ord_data), .i_ram_rd_data(i_ram_rd_data_d), .o_rd_data(o_rd_data_d));

endmodule

// File: tb/tb_zap_regf_wr_sched.sv
// Bench for zap_regf_wr_sched: directed scenarios plus randomized traffic,
// checked against a queue-based model of the pending writes and a reference RAM.
module tb_zap_regf_wr_sched;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_v [3];
    logic [5:0]  req_a [3];
    logic [31:0] req_d [3];
    logic [5:0]  rd_addr [4];
    logic [31:0] ram_rd [4];
    logic [31:0] rd_out [4];
    logic        wr_ready, ram_wen;
    logic [5:0]  wa_addr, wb_addr;
    logic [31:0] wa_data, wb_data;
    logic [2:0]  pending;

    logic [31:0] phys_ram [64];
    logic [31:0] ref_ram  [64];
    wr_t         q    [$];
    wr_t         cand [$];
    bit          last_ready;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    always #5 clk = ~clk;

    zap_regf_wr_sched #(.DEPTH(DEPTH), .AW(6), .DW(32)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_wr_valid_a(req_v[0]), .i_wr_addr_a(req_a[0]), .i_wr_data_a(req_d[0]),
        .i_wr_valid_b(req_v[1]), .i_wr_addr_b(req_a[1]), .i_wr_data_b(req_d[1]),
        .i_wr_valid_c(req_v[2]), .i_wr_addr_c(req_a[2]), .i_wr_data_c(req_d[2]),
        .o_wr_ready(wr_ready), .o_ram_wen(ram_wen),
        .o_ram_wr_addr_a(wa_addr), .o_ram_wr_addr_b(wb_addr),
        .o_ram_wr_data_a(wa_data), .o_ram_wr_data_b(wb_data),
        .i_rd_addr_a(rd_addr[0]), .i_rd_addr_b(rd_addr[1]),
        .i_rd_addr_c(rd_addr[2]), .i_rd_addr_d(rd_addr[3]),
        .i_ram_rd_data_a(ram_rd[0]), .i_ram_rd_data_b(ram_rd[1]),
        .i_ram_rd_data_c(ram_rd[2]), .i_ram_rd_data_d(ram_rd[3]),
        .o_rd_data_a(rd_out[0]), .o_rd_data_b(rd_out[1]),
        .o_rd_data_c(rd_out[2]), .o_rd_data_d(rd_out[3]),
        .o_pending(pending));

    // Physical RAM driven by the DUT write ports.
    always @(posedge clk) begin
        if (ram_wen) begin
            phys_ram[wa_addr] <= wa_data;
            phys_ram[wb_addr] <= wb_data;
        end
    end
    assign ram_rd[0] = phys_ram[rd_addr[0]];
    assign ram_rd[1] = phys_ram[rd_addr[1]];
    assign ram_rd[2] = phys_ram[rd_addr[2]];
    assign ram_rd[3] = phys_ram[rd_addr[3]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        logic [31:0] v;
        v = ref_ram[a];
        foreach (q[i]) if (q[i].a == a) v = q[i].d;
        return v;
    endfunction

    // Settle combinational outputs and compare them with the model.
    task automatic settle();
        bit  rdy;
        wr_t c0, c1;
        #1;
        rdy = (q.size() < DEPTH);
        cand = q;
        for (int j = 0; j < 3; j++)
            if (req_v[j] && rdy) cand.push_back('{a: req_a[j], d: req_d[j]});
        last_ready = rdy;
        chk("ready", 32'(wr_ready), 32'(rdy));
        chk("pending", 32'(pending), q.size());
        for (int k = 0; k < 4; k++) chk("rd_fwd", rd_out[k], model_read(rd_addr[k]));
        if (rst) begin
            chk("wen_in_reset", 32'(ram_wen), 0);
        end else begin
            chk("wen", 32'(ram_wen), 32'(cand.size() != 0));
            if (cand.size() != 0) begin
                c0 = cand[0];
                if (cand.size() == 1) c1 = c0;
                else begin
                    c1 = cand[1];
                    if (c0.a == c1.a) c0 = c1;
                end
                chk("wr_addr_a", 32'(wa_addr), 32'(c0.a));
                chk("wr_data_a", wa_data, c0.d);
                chk("wr_addr_b", 32'(wb_addr), 32'(c1.a));
                chk("wr_data_b", wb_data, c1.d);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (cand.size() != 0) begin
                    ref_ram[cand[0].a] = cand[0].d;
                    void'(cand.pop_front());
                end
            end
            q = cand;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int j, input bit v, input logic [5:0] a, input logic [31:0] d);
        req_v[j] = v; req_a[j] = a; req_d[j] = d;
    endtask

    task automatic clear_req();
        for (int j = 0; j < 3; j++) set_req(j, 1'b0, '0, '0);
    endtask

    task automatic set_rd(input logic [5:0] a);
        for (int k = 0; k < 4; k++) rd_addr[k] = a;
    endtask

    task automatic drain();
        clear_req();
        for (int n = 0; n < 12; n++) begin
            settle();
            if (q.size() == 0) break;
            tick();
        end
        chk("drained", 32'(pending), 0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            phys_ram[i] = '0;
            ref_ram[i]  = '0;
        end
        rst = 1'b1;
        clear_req();
        set_rd(6'd0);
        @(negedge clk);
        settle(); tick();
        settle(); tick();
        rst = 1'b0;
        settle();
        chk("rst_pending", 32'(pending), 0);
        chk("rst_ready", 32'(wr_ready), 1);
        chk("rst_wen", 32'(ram_wen), 0);
        tick();

        // Single write goes straight to RAM.
        set_req(0, 1'b1, 6'd3, 32'h11);
        settle();
        chk("t1_wen", 32'(ram_wen), 1);
        chk("t1_addr_a", 32'(wa_addr), 3);
        chk("t1_addr_b", 32'(wb_addr), 3);
        chk("t1_data_b", wb_data, 32'h11);
        tick();
        clear_req(); set_rd(6'd3);
        settle();
        chk("t1_read", rd_out[0], 32'h11);
        chk("t1_pending", 32'(pending), 0);
        tick();

        // Three in, one queued and forwarded.
        set_req(0, 1'b1, 6'd1, 32'hA);
        set_req(1, 1'b1, 6'd2, 32'hB);
        set_req(2, 1'b1, 6'd4, 32'hC);
        settle();
        chk("t2_addr_a", 32'(wa_addr), 1);
        chk("t2_addr_b", 32'(wb_addr), 2);
        tick();
        clear_req(); set_rd(6'd4);
        settle();
        chk("t2_pending", 32'(pending), 1);
        chk("t2_fwd", rd_out[2], 32'hC);
        chk("t2_wr_addr", 32'(wa_addr), 4);
        tick();
        settle();
        chk("t2_ram_read", rd_out[3], 32'hC);
        tick();

        // Same-address pair: younger wins on both ports.
        set_req(0, 1'b1, 6'd5, 32'h1);
        set_req(1, 1'b1, 6'd5, 32'h2);
        settle();
        chk("t3_addr_a", 32'(wa_addr), 5);
        chk("t3_data_a", wa_data, 32'h2);
        chk("t3_data_b", wb_data, 32'h2);
        tick();
        clear_req(); set_rd(6'd5);
        settle();
        chk("t3_read", rd_out[1], 32'h2);
        tick();

        // Fill to DEPTH, back-pressure with held requests, then drain.
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < 3; j++) set_req(j, 1'b1, 6'(16 + 3 * b + j), $urandom);
            settle();
            chk("t4_pending", 32'(pending), b);
            chk("t4_ready", 32'(wr_ready), 32'(b < 4));
            tick();
        end
        settle();
        chk("t4_after_hold_pending", 32'(pending), 2);
        chk("t4_after_hold_ready", 32'(wr_ready), 1);
        tick();
        drain();

        // Two pending writes to r7: youngest forwarded on every port.
        set_req(0, 1'b1, 6'd10, 32'h10); set_req(1, 1'b1, 6'd11, 32'h11); set_req(2, 1'b1, 6'd12, 32'h12);
        settle(); tick();
        set_req(0, 1'b1, 6'd13, 32'h13); set_req(1, 1'b1, 6'd7, 32'h5); set_req(2, 1'b1, 6'd7, 32'h9);
        settle(); tick();
        clear_req(); set_rd(6'd7);
        settle();
        chk("t5_pending", 32'(pending), 2);
        for (int k = 0; k < 4; k++) chk("t5_fwd", rd_out[k], 32'h9);
        tick();
        drain();

        // Reset with three queued writes discards them.
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 3; j++) set_req(j, 1'b1, 6'(40 + 4 * b + j), 32'hBEEF0000 + 32'(b * 4 + j));
            settle(); tick();
        end
        clear_req(); set_rd(6'd48);
        rst = 1'b1;
        settle();
        chk("t6_pre_pending", 32'(pending), 3);
        tick();
        rst = 1'b0;
        settle();
        chk("t6_pending", 32'(pending), 0);
        chk("t6_wen", 32'(ram_wen), 0);
        chk("t6_ready", 32'(wr_ready), 1);
        chk("t6_not_written", rd_out[0], 0);
        tick();

        // Randomized traffic with back-pressure hold and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if (last_ready || rst) begin
                for (int j = 0; j < 3; j++)
                    set_req(j, ($urandom_range(0, 99) < 75), 6'($urandom_range(0, 7)), $urandom);
            end
            for (int k = 0; k < 4; k++) rd_addr[k] = 6'($urandom_range(0, 7));
            rst = ($urandom_range(0, 199) == 0);
            settle();
            tick();
        end
        rst = 1'b0;
        drain();
        for (int i = 0; i < 64; i++) chk("ram_final", phys_ram[i], ref_ram[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
